// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter in front of one single-port memory.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a REQ/WAIT watchdog that completes with err.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_valid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_err_o,
  output logic                    if_stall_o,

  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb_i,
  output logic                    dm_valid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    dm_err_o,
  output logic                    dm_stall_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e                 state_q, state_d;
  owner_e                 owner_q, last_owner_q;
  logic [ADDR_WIDTH-1:0]  cap_addr_q;
  logic [DATA_WIDTH-1:0]  cap_wdata_q;
  logic [STRB_WIDTH-1:0]  cap_wstrb_q;
  logic                   cap_we_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic win_any, win_dm;
  logic timeout_hit;
  logic resp_if, resp_dm;

  // Ties go to the requester that did not win last time.
  assign win_any = if_req_i | dm_req_i;
  assign win_dm  = dm_req_i & (~if_req_i | (last_owner_q == OWN_IF));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_WIDTH = (CNT_RAW > 8) ? CNT_RAW : 8;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 err_q;

  // Fires on the last allowed REQ/WAIT cycle so the memory sees at most
  // TIMEOUT_CYCLES cycles of activity before the transaction is dropped.
  assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                       (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if ((state_q == REQ) || (state_q == WAIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == REQ && !mem_gnt_i && timeout_hit) ||
          (state_q == WAIT && !mem_rvalid_i && timeout_hit)) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: every variable driven in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (win_any) state_d = REQ;
      REQ: begin
        if (mem_gnt_i)        state_d = WAIT;
        else if (timeout_hit) state_d = RESP;
      end
      WAIT: begin
        if (mem_rvalid_i)     state_d = RESP;
        else if (timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the captured request and response registers are plain flops, not a
    // memory array, so they are cleared on reset to give defined outputs.
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      cap_wstrb_q  <= '0;
      cap_we_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            owner_q      <= win_dm ? OWN_DM : OWN_IF;
            last_owner_q <= win_dm ? OWN_DM : OWN_IF;
            if (win_dm) begin
              cap_addr_q  <= dm_addr_i;
              cap_we_q    <= dm_we_i;
              cap_wdata_q <= dm_wdata_i;
              cap_wstrb_q <= dm_we_i ? dm_wstrb_i : '0;
            end else begin
              cap_addr_q  <= if_addr_i;
              cap_we_q    <= 1'b0;
              cap_wdata_q <= '0;
              cap_wstrb_q <= '0;
            end
          end
        end
        REQ: begin
          if (!mem_gnt_i && timeout_hit) rdata_q <= '0;
        end
        WAIT: begin
          // Write acknowledgements carry no data back to the requester.
          if (mem_rvalid_i)     rdata_q <= cap_we_q ? '0 : mem_rdata_i;
          else if (timeout_hit) rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & cap_we_q;
  assign mem_addr_o  = mem_req_o ? cap_addr_q  : '0;
  assign mem_wdata_o = mem_req_o ? cap_wdata_q : '0;
  assign mem_wstrb_o = mem_req_o ? cap_wstrb_q : '0;

  assign resp_if = (state_q == RESP) && (owner_q == OWN_IF);
  assign resp_dm = (state_q == RESP) && (owner_q == OWN_DM);

  assign if_valid_o = resp_if;
  assign if_rdata_o = resp_if ? rdata_q : '0;
  assign dm_valid_o = resp_dm;
  assign dm_rdata_o = resp_dm ? rdata_q : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  assign if_err_o = resp_if & err_q;
  assign dm_err_o = resp_dm & err_q;
`else
  assign if_err_o = 1'b0;
  assign dm_err_o = 1'b0;
`endif

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign dm_stall_o = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for delayed grant, mid-transaction reset and the watchdog.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_valid, if_err, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_valid, dm_err, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [SW-1:0] dm_wstrb;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid),
    .if_rdata_o(if_rdata), .if_err_o(if_err), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_valid_o(dm_valid),
    .dm_rdata_o(dm_rdata), .dm_err_o(dm_err), .dm_stall_o(dm_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Output groups: {req, we, wstrb, addr, wdata} and {valid, err, stall, rdata}.
  logic [69:0] mem_bus;
  logic [34:0] if_bus, dm_bus;
  assign mem_bus = {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata};
  assign if_bus  = {if_valid, if_err, if_stall, if_rdata};
  assign dm_bus  = {dm_valid, dm_err, dm_stall, dm_rdata};

  localparam logic [69:0] M0 = '0;
  localparam logic [34:0] R0 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] mb(input logic req, input logic we, input logic [3:0] strb,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    return {req, we, strb, addr, wdata};
  endfunction

  function automatic logic [34:0] rb(input logic valid, input logic err, input logic stall,
                                     input logic [31:0] rdata);
    return {valid, err, stall, rdata};
  endfunction

  typedef struct {
    string       name;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [69:0] exp_mem;
    logic [34:0] exp_if;
    logic [34:0] exp_dm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic ireq,
                              input logic [31:0] iaddr, input logic dreq, input logic dwe,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              input logic [3:0] dstrb, input logic gnt, input logic rv,
                              input logic [31:0] rd, input logic [69:0] em,
                              input logic [34:0] ei, input logic [34:0] ed);
    vec_t v;
    v.name = name; v.rst_n = rst; v.if_req = ireq; v.if_addr = iaddr;
    v.dm_req = dreq; v.dm_we = dwe; v.dm_addr = daddr; v.dm_wdata = dwdata;
    v.dm_wstrb = dstrb; v.gnt = gnt; v.rvalid = rv; v.rdata = rd;
    v.exp_mem = em; v.exp_if = ei; v.exp_dm = ed;
    return v;
  endfunction

  task automatic set_idle();
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_wstrb = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [69:0] em,
                           input logic [34:0] ei, input logic [34:0] ed);
    check({name, "/mem"}, mem_bus, em);
    check({name, "/if"},  if_bus,  ei);
    check({name, "/dm"},  dm_bus,  ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    // IF-only read, stray rvalid in RESP.
    vecs.push_back(mk("t1_idle", 1, 1, 32'h100, 0,0,0,0,0, 0,0,0, M0, rb(0,0,1,0), R0));
    vecs.push_back(mk("t1_req",  1, 1, 32'h100, 0,0,0,0,0, 1,0,0, mb(1,0,0,32'h100,0), rb(0,0,1,0), R0));
    vecs.push_back(mk("t1_wait", 1, 1, 32'h100, 0,0,0,0,0, 0,1,32'hDEADBEEF, M0, rb(0,0,1,0), R0));
    vecs.push_back(mk("t1_resp", 1, 1, 32'h100, 0,0,0,0,0, 0,1,32'h11111111, M0, rb(1,0,0,32'hDEADBEEF), R0));
    vecs.push_back(mk("t1_done", 1, 0, 0, 0,0,0,0,0, 0,0,0, M0, R0, R0));
    vecs.push_back(mk("t2_rst",  0, 0, 0, 0,0,0,0,0, 0,0,0, M0, R0, R0));
    // Simultaneous requests after reset: DM, IF, DM.
    vecs.push_back(mk("t2_tie1",  1, 1,32'h100, 1,0,32'h40,0,4'hF, 0,0,0, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_dreq1", 1, 1,32'h100, 1,0,32'h40,0,4'hF, 1,0,0, mb(1,0,0,32'h40,0), rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_dwt1",  1, 1,32'h100, 1,0,32'h40,0,4'hF, 0,1,32'hA, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_drsp1", 1, 1,32'h100, 1,0,32'h40,0,4'hF, 0,0,0, M0, rb(0,0,1,0), rb(1,0,0,32'hA)));
    vecs.push_back(mk("t2_tie2",  1, 1,32'h100, 1,0,32'h44,0,0, 0,0,0, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_ireq",  1, 1,32'h100, 1,0,32'h44,0,0, 1,0,0, mb(1,0,0,32'h100,0), rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_iwt",   1, 1,32'h100, 1,0,32'h44,0,0, 0,1,32'hB, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_irsp",  1, 1,32'h100, 1,0,32'h44,0,0, 0,0,0, M0, rb(1,0,0,32'hB), rb(0,0,1,0)));
    vecs.push_back(mk("t2_tie3",  1, 1,32'h100, 1,0,32'h44,0,0, 0,0,0, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_dreq2", 1, 1,32'h100, 1,0,32'h44,0,0, 1,0,0, mb(1,0,0,32'h44,0), rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_dwt2",  1, 1,32'h100, 1,0,32'h44,0,0, 0,1,32'hC, M0, rb(0,0,1,0), rb(0,0,1,0)));
    vecs.push_back(mk("t2_drsp2", 1, 1,32'h100, 1,0,32'h44,0,0, 0,0,0, M0, rb(0,0,1,0), rb(1,0,0,32'hC)));
    vecs.push_back(mk("t2_done",  1, 0,0, 0,0,0,0,0, 0,0,0, M0, R0, R0));
    // Stray rvalid in IDLE, then a normal fetch.
    vecs.push_back(mk("t6_stray0", 1, 0,0, 0,0,0,0,0, 0,1,32'hFFFFFFFF, M0, R0, R0));
    vecs.push_back(mk("t6_stray1", 1, 0,0, 0,0,0,0,0, 0,1,32'h0BADF00D, M0, R0, R0));
    vecs.push_back(mk("t6_idle",   1, 1,32'h200, 0,0,0,0,0, 0,0,0, M0, rb(0,0,1,0), R0));
    vecs.push_back(mk("t6_req",    1, 1,32'h200, 0,0,0,0,0, 1,0,0, mb(1,0,0,32'h200,0), rb(0,0,1,0), R0));
    vecs.push_back(mk("t6_wait",   1, 1,32'h200, 0,0,0,0,0, 0,1,32'h600D, M0, rb(0,0,1,0), R0));
    vecs.push_back(mk("t6_resp",   1, 1,32'h200, 0,0,0,0,0, 0,0,0, M0, rb(1,0,0,32'h600D), R0));
    vecs.push_back(mk("t6_done",   1, 0,0, 0,0,0,0,0, 0,0,0, M0, R0, R0));

    set_idle();
    rst_n = 0;
    step();
    step();
    check_all("reset", M0, R0, R0);
    rst_n = 1;

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_wstrb = vecs[i].dm_wstrb;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      #1;
      check_all(vecs[i].name, vecs[i].exp_mem, vecs[i].exp_if, vecs[i].exp_dm);
      step();
    end
    rst_n = 1;
    set_idle();

    // DM store with grant delayed 3 cycles; rvalid in REQ must be ignored.
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      mem_rvalid = (i == 0);
      mem_rdata = 32'h77777777;
      #1;
      check("t3_req_hold", mem_bus, mb(1,1,4'b0011,32'h2000,32'h12345678));
      check("t3_no_early_valid", dm_bus, rb(0,0,1,0));
      step();
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("t3_wait_mem", mem_bus, M0);
    step();
    mem_rvalid = 0;
    #1;
    check("t3_resp", dm_bus, rb(1,0,0,0));
    step();
    dm_req = 0;
    #1;
    check("t3_single_pulse", dm_bus, R0);
    step();
    set_idle();

    // Reset while in WAIT; the late rvalid must not produce a valid pulse.
    if_req = 1; if_addr = 32'h300;
    step();
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    rst_n = 0; if_req = 0;
    #1;
    check("t4_in_wait", mem_bus, M0);
    step();
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hBAD;
    #1;
    check_all("t4_late_rvalid", M0, R0, R0);
    step();
    mem_rvalid = 0;
    #1;
    check_all("t4_no_valid", M0, R0, R0);
    if_req = 1; if_addr = 32'h304;
    #1;
    check("t4_idle_again", mem_bus, M0);
    step();
    mem_gnt = 1;
    #1;
    check("t4_new_req", mem_bus, mb(1,0,0,32'h304,0));
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    step();
    mem_rvalid = 0;
    #1;
    check("t4_new_resp", if_bus, rb(1,0,0,32'h1234));
    step();
    set_idle();

    // Memory never grants.
    if_req = 1; if_addr = 32'h400;
    step();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      #1;
      check("t5_req_until_timeout", mem_bus, mb(1,0,0,32'h400,0));
      check("t5_no_err_yet", if_bus, rb(0,0,1,0));
      step();
    end
    #1;
    check("t5_timeout_mem", mem_bus, M0);
    check("t5_timeout_resp", if_bus, rb(1,1,0,0));
    step();
    if_req = 0;
    #1;
    check_all("t5_after", M0, R0, R0);
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t5_req_held", mem_bus, mb(1,0,0,32'h400,0));
      check("t5_never_err", if_bus, rb(0,0,1,0));
      step();
    end
    rst_n = 0; if_req = 0;
    step();
    rst_n = 1;
    #1;
    check_all("t5_after_reset", M0, R0, R0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between the instruction-fetch requester (IF) and the load/store requester (DM) of the RV32 pipeline. The load/store requester is driven by the MEM-stage `mem_re`/`mem_we` control bits. The block arbitrates between the two, issues exactly one memory transaction at a time, and returns the response to whichever requester won. It also emits stall signals to the pipeline while a request is pending.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; must be a multiple of 8
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock; all logic on its rising edge
rst_n  in  1  reset, synchronous, active-low
if_req_i  in  1  fetch request; level, held until if_valid_o
if_addr_i  in  ADDR_WIDTH  fetch address
if_valid_o  out  1  one-cycle pulse: fetch complete
if_rdata_o  out  DATA_WIDTH  fetch data; valid with if_valid_o
if_err_o  out  1  fetch timed out; valid with if_valid_o
if_stall_o  out  1  if_req_i & ~if_valid_o
dm_req_i  in  1  data request; level, held until dm_valid_o
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  ADDR_WIDTH  data address
dm_wdata_i  in  DATA_WIDTH  store data
dm_wstrb_i  in  DATA_WIDTH/8  store byte enables
dm_valid_o  out  1  one-cycle pulse: data access complete
dm_rdata_o  out  DATA_WIDTH  load data; valid with dm_valid_o
dm_err_o  out  1  data access timed out; valid with dm_valid_o
dm_stall_o  out  1  dm_req_i & ~dm_valid_o
mem_req_o  out  1  memory request; held until mem_gnt_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_wstrb_o  out  DATA_WIDTH/8  memory byte enables; 0 for reads
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  memory response; pulses for reads and writes
mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - Reset `rst_n` is synchronous and active-low.
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset values:
  - State goes to IDLE; owner goes to IF; last_owner goes to IF.
  - All `_o` outputs are 0. Captured addr/wdata/wstrb/we/rdata registers are 0.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Only one request high: that requester wins.
  - Both requests high: the requester opposite to last_owner wins. Reset last_owner = IF, so DM wins the first tie.
  - On a win:
    - Capture the winner's addr; for DM also capture we/wdata/wstrb. An IF win captures we = 0 and wstrb = 0.
    - Set owner and last_owner to the winner; go to REQ.
- REQ:
  - mem_req_o = 1, with mem_* driven from the captured registers.
  - mem_gnt_i = 1: go to WAIT.
  - mem_gnt_i = 0: stay in REQ with outputs stable.
  - mem_rvalid_i is ignored in REQ.
- WAIT:
  - mem_req_o = 0.
  - mem_rvalid_i = 1: register mem_rdata_i (store 0 for a DM write), then go to RESP.
- RESP (exactly one cycle):
  - Assert the owner's valid_o and drive its rdata_o; the other requester's valid/rdata stay 0.
  - Next state is IDLE.
- Requester contract:
  - The requester deasserts req at the edge after it sees valid_o, so IDLE does not re-serve a completed request.
  - Requester inputs may change while not owner. The captured values are used regardless.
- Latency:
  - Minimum request-to-valid is 4 cycles: IDLE sample, REQ with gnt, WAIT with rvalid, RESP.
  - Each extra cycle without gnt or rvalid adds 1.
- Throughput: one transaction in flight at most; back-to-back transactions every 4 cycles minimum.
- Stray responses: mem_rvalid_i in IDLE or RESP is ignored.
- Reset mid-transaction: the FSM returns to IDLE immediately and the pending transaction is abandoned. A late mem_rvalid_i is then ignored.
- Stall outputs: if_stall_o and dm_stall_o are combinational and depend only on the request and valid signals.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: mem_req_o drops, registered rdata = 0, state goes to RESP, and the owner's err_o = 1 together with its valid_o.
  - If gnt or rvalid arrives in the same cycle as the timeout, the normal path wins and err_o = 0.
- Undefined: no counter is built; if_err_o and dm_err_o are tied to 0; REQ and WAIT may last indefinitely.

Test Plan:
1. IF only, if_addr_i=0x100, gnt same cycle as mem_req_o, rvalid next cycle with rdata 0xDEADBEEF -> if_valid_o pulses 4 cycles after req with if_rdata_o=0xDEADBEEF; mem_we_o=0 and mem_wstrb_o=0 throughout.
2. if_req and dm_req both rise in the same cycle after reset -> DM served first. With IF held and DM re-requesting, the next grant goes to IF, then DM (strict alternation).
3. DM store, addr 0x2000, wdata 0x12345678, wstrb 0b0011, gnt delayed 3 cycles -> mem_req_o held 4 cycles with stable addr/data/strb; dm_valid_o pulses once; dm_rdata_o=0.
4. rst_n low for 1 cycle while in WAIT, then rvalid arrives -> no valid_o pulse; state IDLE; all outputs 0.
5. With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never grants -> mem_req_o drops after 8 cycles; if_valid_o=1 with if_err_o=1 and if_rdata_o=0. Without the macro -> mem_req_o stays high; if_err_o is never asserted.
6. Stray mem_rvalid_i pulses in IDLE -> no valid_o; next real request completes normally.
